regfile_param: RTL and testbench



---
 rtl/regfile_param_if.sv | 31 +++
 rtl/regfile_param.sv | 128 ++++++++++++
 tb/tb_regfile_param.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Register-file port bundle: write port, flag/lock controls, two read ports and their status.
// master drives writes and read addresses; slave is the register file.
interface regfile_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              flag_en;
   logic              lock_en;
   logic [ADDR_W-1:0] lock_addr;
   logic [ADDR_W-1:0] rd_addr_d;
   logic [ADDR_W-1:0] rd_addr_s;
   logic [DATA_W-1:0] dbus;
   logic [DATA_W-1:0] sbus;
   logic              d_pend;
   logic              s_pend;
   logic              zero;
   logic              negative;

   modport master (
      output wr_en, wr_addr, wr_data, flag_en, lock_en, lock_addr, rd_addr_d, rd_addr_s,
      input  dbus, sbus, d_pend, s_pend, zero, negative
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, flag_en, lock_en, lock_addr, rd_addr_d, rd_addr_s,
      output dbus, sbus, d_pend, s_pend, zero, negative
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports with optional
// same-cycle forwarding, registered zero/negative flags and a per-register pending scoreboard.
module regfile_param #(
   parameter int DATA_W  = 8,
   parameter int NREGS   = 4,
   parameter int ADDR_W  = $clog2(NREGS),
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   regfile_param_if.slave    bus
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  pend_q;
   logic [NREGS-1:0]  pend_d;
   logic              zero_q;
   logic              zero_d;
   logic              neg_q;
   logic              neg_d;

   logic              wr_r0_s;
   logic              d_r0_s;
   logic              s_r0_s;
   logic              d_fwd_s;
   logic              s_fwd_s;

   function automatic logic is_zero(input logic [DATA_W-1:0] v);
      return ~|v;
   endfunction

   // Decode hard-wired R0 and forwarding hits for the write port and both read ports.
   always_comb begin
      wr_r0_s = (ZERO_R0 != 0) && (bus.wr_addr   == {ADDR_W{1'b0}});
      d_r0_s  = (ZERO_R0 != 0) && (bus.rd_addr_d == {ADDR_W{1'b0}});
      s_r0_s  = (ZERO_R0 != 0) && (bus.rd_addr_s == {ADDR_W{1'b0}});
      d_fwd_s = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr_d);
      s_fwd_s = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr_s);
   end

   // Next-state for storage, scoreboard and flags; a lock overrides a same-address write-back.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      zero_d = zero_q;
      neg_d  = neg_q;
      if (bus.wr_en && !wr_r0_s) begin
         regs_d[bus.wr_addr] = bus.wr_data;
      end else begin
         regs_d = regs_q;
      end
      if (bus.wr_en) begin
         pend_d[bus.wr_addr] = 1'b0;
      end else begin
         pend_d = pend_q;
      end
      if (bus.lock_en) begin
         pend_d[bus.lock_addr] = 1'b1;
      end else begin
         pend_d = pend_d;
      end
      if (ZERO_R0 != 0) begin
         pend_d[0] = 1'b0;
         regs_d[0] = {DATA_W{1'b0}};
      end else begin
         pend_d = pend_d;
      end
      // Flags follow wr_data even when an R0 write is discarded.
      if (bus.wr_en && bus.flag_en) begin
         zero_d = is_zero(bus.wr_data);
         neg_d  = bus.wr_data[DATA_W-1];
      end else begin
         zero_d = zero_q;
         neg_d  = neg_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         pend_q <= {NREGS{1'b0}};
         zero_q <= 1'b1;
         neg_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
         zero_q <= zero_d;
         neg_q  <= neg_d;
      end
   end

   // Destination-bus read port.
   always_comb begin
      if (d_r0_s) begin
         bus.dbus   = {DATA_W{1'b0}};
         bus.d_pend = 1'b0;
      end else if (d_fwd_s) begin
         bus.dbus   = bus.wr_data;
         bus.d_pend = 1'b0;
      end else begin
         bus.dbus   = regs_q[bus.rd_addr_d];
         bus.d_pend = pend_q[bus.rd_addr_d];
      end
   end

   // Source-bus read port.
   always_comb begin
      if (s_r0_s) begin
         bus.sbus   = {DATA_W{1'b0}};
         bus.s_pend = 1'b0;
      end else if (s_fwd_s) begin
         bus.sbus   = bus.wr_data;
         bus.s_pend = 1'b0;
      end else begin
         bus.sbus   = regs_q[bus.rd_addr_s];
         bus.s_pend = pend_q[bus.rd_addr_s];
      end
   end

   assign bus.zero     = zero_q;
   assign bus.negative = neg_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param across four configurations:
// A (8x4, no bypass), B (8x4, bypass), C (16x8, bypass, hard R0), D (32x16, no bypass).
module tb_regfile_param;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   regfile_param_if #(.DATA_W(8),  .ADDR_W(2)) ia ();
   regfile_param_if #(.DATA_W(8),  .ADDR_W(2)) ib ();
   regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ic ();
   regfile_param_if #(.DATA_W(32), .ADDR_W(4)) id ();

   regfile_param #(.DATA_W(8),  .NREGS(4),  .BYPASS(0), .ZERO_R0(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   regfile_param #(.DATA_W(8),  .NREGS(4),  .BYPASS(1), .ZERO_R0(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
   regfile_param #(.DATA_W(16), .NREGS(8),  .BYPASS(1), .ZERO_R0(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
   regfile_param #(.DATA_W(32), .NREGS(16), .BYPASS(0), .ZERO_R0(0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(id));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_all();
      ia.wr_en = 1'b0; ia.flag_en = 1'b0; ia.lock_en = 1'b0;
      ib.wr_en = 1'b0; ib.flag_en = 1'b0; ib.lock_en = 1'b0;
      ic.wr_en = 1'b0; ic.flag_en = 1'b0; ic.lock_en = 1'b0;
      id.wr_en = 1'b0; id.flag_en = 1'b0; id.lock_en = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      ia.wr_en = 1'b1; ia.wr_addr = 2'd2; ia.wr_data = 8'hA5; ia.flag_en = 1'b1;
      ia.lock_en = 1'b1; ia.lock_addr = 2'd2; ia.rd_addr_d = 2'd2; ia.rd_addr_s = 2'd2;
      #2 rst_n = 1'b0;
      #1;
      if (ia.dbus !== 8'h00) begin mismatched++; $display("FAIL rst_dbus got %h exp 00", ia.dbus); end compared++;
      if (ia.sbus !== 8'h00) begin mismatched++; $display("FAIL rst_sbus got %h exp 00", ia.sbus); end compared++;
      if (ia.zero !== 1'b1) begin mismatched++; $display("FAIL rst_zero got %b exp 1", ia.zero); end compared++;
      if (ia.negative !== 1'b0) begin mismatched++; $display("FAIL rst_neg got %b exp 0", ia.negative); end compared++;
      if (ia.d_pend !== 1'b0 || ia.s_pend !== 1'b0) begin mismatched++; $display("FAIL rst_pend got %b%b exp 00", ia.d_pend, ia.s_pend); end compared++;
      @(posedge clk); #1;
      if (ia.dbus !== 8'h00 || ia.zero !== 1'b1) begin mismatched++; $display("FAIL rst_edge got %h/%b exp 00/1", ia.dbus, ia.zero); end compared++;
      idle_all();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      if (ia.dbus !== 8'h00) begin mismatched++; $display("FAIL rst_r2_after got %h exp 00", ia.dbus); end compared++;
      if (ia.d_pend !== 1'b0) begin mismatched++; $display("FAIL rst_pend_after got %b exp 0", ia.d_pend); end compared++;
      if (ic.zero !== 1'b1 || id.zero !== 1'b1 || ib.negative !== 1'b0) begin mismatched++; $display("FAIL rst_flags_all got %b%b%b exp 110", ic.zero, id.zero, ib.negative); end compared++;
   endtask

   task automatic test_write_read_nobypass();
      @(negedge clk);
      ia.wr_en = 1'b1; ia.wr_addr = 2'd1; ia.wr_data = 8'h80; ia.flag_en = 1'b1; ia.rd_addr_d = 2'd1;
      #1;
      if (ia.dbus !== 8'h00) begin mismatched++; $display("FAIL nb_same_cycle got %h exp 00", ia.dbus); end compared++;
      @(posedge clk); #1;
      idle_all(); #1;
      if (ia.dbus !== 8'h80) begin mismatched++; $display("FAIL nb_next got %h exp 80", ia.dbus); end compared++;
      if (ia.negative !== 1'b1 || ia.zero !== 1'b0) begin mismatched++; $display("FAIL nb_flags got n%b z%b exp n1 z0", ia.negative, ia.zero); end compared++;
   endtask

   task automatic test_bypass();
      @(negedge clk);
      ib.wr_en = 1'b1; ib.wr_addr = 2'd3; ib.wr_data = 8'h3C; ib.rd_addr_d = 2'd3; ib.rd_addr_s = 2'd3;
      #1;
      if (ib.dbus !== 8'h3C || ib.sbus !== 8'h3C) begin mismatched++; $display("FAIL byp_fwd got %h/%h exp 3c/3c", ib.dbus, ib.sbus); end compared++;
      @(posedge clk); #1;
      idle_all(); #1;
      if (ib.dbus !== 8'h3C) begin mismatched++; $display("FAIL byp_stored got %h exp 3c", ib.dbus); end compared++;
      if (ib.zero !== 1'b1) begin mismatched++; $display("FAIL byp_noflag got %b exp 1", ib.zero); end compared++;
      @(negedge clk);
      ib.wr_en = 1'b1; ib.wr_addr = 2'd0; ib.wr_data = 8'h81; ib.flag_en = 1'b1;
      @(posedge clk); #1;
      if (ib.zero !== 1'b0 || ib.negative !== 1'b1) begin mismatched++; $display("FAIL byp_flag81 got z%b n%b exp z0 n1", ib.zero, ib.negative); end compared++;
      @(negedge clk);
      ib.wr_data = 8'h00;
      @(posedge clk); #1;
      if (ib.zero !== 1'b1 || ib.negative !== 1'b0) begin mismatched++; $display("FAIL byp_flag00 got z%b n%b exp z1 n0", ib.zero, ib.negative); end compared++;
      @(negedge clk);
      ib.wr_data = 8'hFF; ib.flag_en = 1'b0;
      @(posedge clk); #1;
      if (ib.zero !== 1'b1 || ib.negative !== 1'b0) begin mismatched++; $display("FAIL byp_flag_hold got z%b n%b exp z1 n0", ib.zero, ib.negative); end compared++;
      idle_all();
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      ia.lock_en = 1'b1; ia.lock_addr = 2'd2; ia.rd_addr_d = 2'd2;
      ib.lock_en = 1'b1; ib.lock_addr = 2'd2; ib.rd_addr_d = 2'd2;
      #1;
      if (ia.d_pend !== 1'b0 || ib.d_pend !== 1'b0) begin mismatched++; $display("FAIL sb_lock_early got %b%b exp 00", ia.d_pend, ib.d_pend); end compared++;
      @(posedge clk); #1;
      idle_all(); #1;
      if (ia.d_pend !== 1'b1 || ib.d_pend !== 1'b1) begin mismatched++; $display("FAIL sb_lock got %b%b exp 11", ia.d_pend, ib.d_pend); end compared++;
      @(negedge clk);
      ia.lock_en = 1'b1; ia.wr_en = 1'b1; ia.wr_addr = 2'd2; ia.wr_data = 8'h11;
      ib.lock_en = 1'b1; ib.wr_en = 1'b1; ib.wr_addr = 2'd2; ib.wr_data = 8'h11;
      #1;
      if (ia.d_pend !== 1'b1 || ib.d_pend !== 1'b0) begin mismatched++; $display("FAIL sb_lockwr_cur got %b%b exp 10", ia.d_pend, ib.d_pend); end compared++;
      @(posedge clk); #1;
      idle_all(); #1;
      if (ia.d_pend !== 1'b1 || ib.d_pend !== 1'b1) begin mismatched++; $display("FAIL sb_lock_wins got %b%b exp 11", ia.d_pend, ib.d_pend); end compared++;
      @(negedge clk);
      ia.wr_en = 1'b1; ia.wr_addr = 2'd2; ia.wr_data = 8'h22;
      ib.wr_en = 1'b1; ib.wr_addr = 2'd2; ib.wr_data = 8'h22;
      ia.lock_en = 1'b1; ia.lock_addr = 2'd0; ia.rd_addr_s = 2'd0;
      #1;
      if (ia.d_pend !== 1'b1 || ib.d_pend !== 1'b0) begin mismatched++; $display("FAIL sb_wr_cur got %b%b exp 10", ia.d_pend, ib.d_pend); end compared++;
      @(posedge clk); #1;
      idle_all(); #1;
      if (ia.d_pend !== 1'b0 || ib.d_pend !== 1'b0) begin mismatched++; $display("FAIL sb_wr_next got %b%b exp 00", ia.d_pend, ib.d_pend); end compared++;
      if (ia.s_pend !== 1'b1) begin mismatched++; $display("FAIL sb_diff_addr got %b exp 1", ia.s_pend); end compared++;
      if (ia.dbus !== 8'h22) begin mismatched++; $display("FAIL sb_data got %h exp 22", ia.dbus); end compared++;
   endtask

   task automatic test_zero_r0();
      @(negedge clk);
      ic.wr_en = 1'b1; ic.wr_addr = 3'd0; ic.wr_data = 16'hFFFF; ic.flag_en = 1'b1;
      ic.rd_addr_d = 3'd0; ic.rd_addr_s = 3'd0;
      #1;
      if (ic.dbus !== 16'h0000 || ic.sbus !== 16'h0000) begin mismatched++; $display("FAIL r0_fwd got %h/%h exp 0000", ic.dbus, ic.sbus); end compared++;
      @(posedge clk); #1;
      idle_all(); #1;
      if (ic.dbus !== 16'h0000) begin mismatched++; $display("FAIL r0_stored got %h exp 0000", ic.dbus); end compared++;
      if (ic.negative !== 1'b1 || ic.zero !== 1'b0) begin mismatched++; $display("FAIL r0_flags got n%b z%b exp n1 z0", ic.negative, ic.zero); end compared++;
      @(negedge clk);
      ic.lock_en = 1'b1; ic.lock_addr = 3'd0;
      @(posedge clk); #1;
      idle_all(); #1;
      if (ic.d_pend !== 1'b0) begin mismatched++; $display("FAIL r0_lock got %b exp 0", ic.d_pend); end compared++;
      @(negedge clk);
      ic.wr_en = 1'b1; ic.wr_addr = 3'd7; ic.wr_data = 16'hFFFF; ic.lock_en = 1'b1; ic.lock_addr = 3'd6;
      ic.rd_addr_d = 3'd7; ic.rd_addr_s = 3'd6;
      @(posedge clk); #1;
      idle_all(); #1;
      if (ic.dbus !== 16'hFFFF) begin mismatched++; $display("FAIL r0_r7 got %h exp ffff", ic.dbus); end compared++;
      if (ic.s_pend !== 1'b1) begin mismatched++; $display("FAIL r0_r6_pend got %b exp 1", ic.s_pend); end compared++;
   endtask

   task automatic test_width_sweep();
      logic [31:0] v;
      logic [31:0] vs;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         id.wr_en = 1'b1; id.wr_addr = 4'(i); id.wr_data = 32'hC0DE_0000 | (32'(i) * 32'h0001_0101);
         @(posedge clk); #1;
      end
      idle_all();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         id.rd_addr_d = 4'(i); id.rd_addr_s = 4'(15 - i);
         v  = 32'hC0DE_0000 | (32'(i) * 32'h0001_0101);
         vs = 32'hC0DE_0000 | (32'(15 - i) * 32'h0001_0101);
         #1;
         if (id.dbus !== v) begin mismatched++; $display("FAIL sweep_d[%0d] got %h exp %h", i, id.dbus, v); end compared++;
         if (id.sbus !== vs) begin mismatched++; $display("FAIL sweep_s[%0d] got %h exp %h", 15 - i, id.sbus, vs); end compared++;
      end
      @(negedge clk);
      id.wr_en = 1'b1; id.wr_addr = 4'd5; id.wr_data = 32'h8000_0000; id.flag_en = 1'b1; id.rd_addr_d = 4'd5;
      @(posedge clk); #1;
      idle_all(); #1;
      if (id.negative !== 1'b1 || id.zero !== 1'b0) begin mismatched++; $display("FAIL sweep_flags got n%b z%b exp n1 z0", id.negative, id.zero); end compared++;
      if (id.dbus !== 32'h8000_0000) begin mismatched++; $display("FAIL sweep_r5 got %h exp 80000000", id.dbus); end compared++;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      idle_all();
      ia.wr_addr = 2'd0; ia.wr_data = 8'h00; ia.lock_addr = 2'd0; ia.rd_addr_d = 2'd0; ia.rd_addr_s = 2'd0;
      ib.wr_addr = 2'd0; ib.wr_data = 8'h00; ib.lock_addr = 2'd0; ib.rd_addr_d = 2'd0; ib.rd_addr_s = 2'd0;
      ic.wr_addr = 3'd0; ic.wr_data = 16'h0000; ic.lock_addr = 3'd0; ic.rd_addr_d = 3'd0; ic.rd_addr_s = 3'd0;
      id.wr_addr = 4'd0; id.wr_data = 32'h0; id.lock_addr = 4'd0; id.rd_addr_d = 4'd0; id.rd_addr_s = 4'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_write_read_nobypass();
      test_bypass();
      test_scoreboard();
      test_zero_r0();
      test_width_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
